wave_meter: RTL and testbench

WAVE_METER -- requirements
Module: wave_meter

---
 rtl/wave_meter.sv | 123 ++++++++++++
 tb/tb_wave_meter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_meter.sv
// Period, peak and trough meter for an 8-bit ADC waveform. The input is sampled once
// per prescaler period, and rising midcode crossings with hysteresis delimit each period.
module wave_meter #(
   parameter int DIV    = 10,
   parameter int HYST   = 8,
   parameter int MAXPER = 4095
) (
   input  logic        inclk,
   input  logic        rst,
   input  logic [7:0]  din,
   output logic [11:0] Qper,
   output logic [7:0]  Qmax,
   output logic [7:0]  Qmin,
   output logic        valid,
   output logic        timeout
);

   localparam int               CNT_W   = (DIV < 1) ? 1 : $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DIV);
   localparam logic [8:0]       HI      = 9'(128 + HYST);
   localparam logic [8:0]       LO      = 9'(128 - HYST);
   localparam logic [11:0]      PER_MAX = 12'(MAXPER);

   typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, RUN_LOW, RUN_HIGH} state_t;

   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   logic [CNT_W-1:0] cnt;
   logic             stb_p0;
   logic [7:0]       s_p1;
   logic             vld_p1;
   logic             is_hi;
   logic             is_lo;
   state_t           state;
   logic [11:0]      per;
   logic [7:0]       runmax;
   logic [7:0]       runmin;

   // p0: prescaler and sample strobe
   assign stb_p0 = (cnt == CNT_TC);

   always_ff @(posedge inclk) begin
      if (rst)         cnt <= '0;
      else if (stb_p0) cnt <= '0;
      else             cnt <= cnt + 1'b1;
   end

   // p1: captured sample, valid for decisions one clock after the strobe
   always_ff @(posedge inclk) begin
      if (rst) begin
         s_p1   <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= stb_p0;
         if (stb_p0) s_p1 <= din;
      end
   end

   assign is_hi = ({1'b0, s_p1} >= HI);
   assign is_lo = ({1'b0, s_p1} <= LO);

   // p2: crossing FSM and registered measurement outputs
   always_ff @(posedge inclk) begin
      if (rst) begin
         state   <= SEEK_LOW;
         per     <= '0;
         runmax  <= 8'd0;
         runmin  <= 8'd255;
         Qper    <= '0;
         Qmax    <= '0;
         Qmin    <= '0;
         valid   <= 1'b0;
         timeout <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         if (vld_p1) begin
            case (state)
               SEEK_LOW: begin
                  if (is_lo) state <= SEEK_HIGH;
               end
               SEEK_HIGH: begin
                  if (is_hi) begin
                     per    <= 12'd1;
                     runmax <= s_p1;
                     runmin <= s_p1;
                     state  <= RUN_LOW;
                  end
               end
               RUN_LOW, RUN_HIGH: begin
                  if (state == RUN_HIGH && is_hi) begin
                     // the crossing sample closes this period and opens the next
                     Qper   <= per;
                     Qmax   <= max8(runmax, s_p1);
                     Qmin   <= min8(runmin, s_p1);
                     valid  <= 1'b1;
                     per    <= 12'd1;
                     runmax <= s_p1;
                     runmin <= s_p1;
                     state  <= RUN_LOW;
                  end else if (per >= PER_MAX) begin
                     timeout <= 1'b1;
                     state   <= SEEK_LOW;
                  end else begin
                     per    <= per + 12'd1;
                     runmax <= max8(runmax, s_p1);
                     runmin <= min8(runmin, s_p1);
                     if (state == RUN_LOW && is_lo) state <= RUN_HIGH;
                  end
               end
               default: state <= SEEK_LOW;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter: reset, triangle, in-band noise, timeout, square wave
// and reset in the middle of a period, all with hand-computed expectations.
module tb_wave_meter;

   logic        inclk = 1'b0;
   logic        rst   = 1'b1;
   logic [7:0]  din   = 8'd0;
   logic [11:0] Qper;
   logic [7:0]  Qmax;
   logic [7:0]  Qmin;
   logic        valid;
   logic        timeout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nvalid = 0;
   int nto    = 0;
   int nboth  = 0;
   int nlong  = 0;
   int vprev  = 0;
   int vlast  = 0;
   int tocyc  = 0;
   logic valid_d = 1'b0;

   wave_meter #(.DIV(10), .HYST(8), .MAXPER(4095)) dut (
      .inclk   (inclk),
      .rst     (rst),
      .din     (din),
      .Qper    (Qper),
      .Qmax    (Qmax),
      .Qmin    (Qmin),
      .valid   (valid),
      .timeout (timeout)
   );

   always #5 inclk = ~inclk;

   always @(posedge inclk) cyc <= cyc + 1;

   // pulse monitor, sampled on the falling edge
   always @(negedge inclk) begin
      valid_d <= valid;
      if (valid) begin
         nvalid <= nvalid + 1;
         vprev  <= vlast;
         vlast  <= cyc;
         if (valid_d) nlong <= nlong + 1;
      end
      if (timeout) begin
         nto   <= nto + 1;
         tocyc <= cyc;
      end
      if (valid && timeout) nboth <= nboth + 1;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge inclk);
      rst = 1'b1;
      din = 8'd0;
      repeat (3) @(negedge inclk);
      rst = 1'b0;
   endtask

   // one sample period; din is disturbed early and settles before the strobe edge
   task automatic feed(input logic [7:0] v);
      #1 din = ~v;
      repeat (5) @(posedge inclk);
      #1 din = v;
      repeat (6) @(posedge inclk);
   endtask

   task automatic settle();
      repeat (3) @(posedge inclk);
      #1;
   endtask

   task automatic test_reset();
      int first;
      do_reset();
      checks++; if (Qper !== 12'd0) begin errors++; $display("FAIL reset_qper got %0d want 0", Qper); end
      checks++; if (Qmax !== 8'd0) begin errors++; $display("FAIL reset_qmax got %0d want 0", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL reset_qmin got %0d want 0", Qmin); end
      checks++; if ({valid, timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {valid, timeout}); end
      first = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge inclk);
         @(negedge inclk);
         if (dut.stb_p0 && first == 0) first = k + 1;
      end
      checks++; if (first !== 11) begin errors++; $display("FAIL reset_first_stb got %0d want 11", first); end
   endtask

   task automatic test_triangle();
      int v0, idx, val;
      do_reset();
      v0 = nvalid;
      for (int i = 0; i < 75; i++) begin
         idx = i % 30;
         val = (idx < 16) ? 16 * idx : 16 * (30 - idx);
         feed(8'(val));
      end
      settle();
      checks++; if (nvalid - v0 !== 2) begin errors++; $display("FAIL tri_count got %0d want 2", nvalid - v0); end
      checks++; if (Qper !== 12'd30) begin errors++; $display("FAIL tri_qper got %0d want 30", Qper); end
      checks++; if (Qmax !== 8'd240) begin errors++; $display("FAIL tri_qmax got %0d want 240", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL tri_qmin got %0d want 0", Qmin); end
      checks++; if (vlast - vprev !== 330) begin errors++; $display("FAIL tri_spacing got %0d want 330", vlast - vprev); end
      checks++; if (nlong !== 0) begin errors++; $display("FAIL tri_pulse_width got %0d want 0", nlong); end
   endtask

   task automatic test_noise();
      int v0;
      do_reset();
      v0 = nvalid;
      feed(8'd0);
      for (int i = 0; i < 100; i++) feed((i % 2 == 0) ? 8'd130 : 8'd126);
      feed(8'd200);
      feed(8'd0);
      checks++; if (nvalid !== v0) begin errors++; $display("FAIL noise_no_valid got %0d want %0d", nvalid, v0); end
      feed(8'd0);
      feed(8'd0);
      feed(8'd200);
      for (int i = 0; i < 6; i++) begin
         feed((i % 2 == 0) ? 8'd130 : 8'd126);
         if (i == 0) begin
            checks++; if (Qper !== 12'd4) begin errors++; $display("FAIL noise_first_qper got %0d want 4", Qper); end
         end
      end
      feed(8'd0);
      feed(8'd200);
      settle();
      checks++; if (nvalid - v0 !== 2) begin errors++; $display("FAIL noise_count got %0d want 2", nvalid - v0); end
      checks++; if (Qper !== 12'd8) begin errors++; $display("FAIL noise_qper got %0d want 8", Qper); end
      checks++; if (Qmax !== 8'd200) begin errors++; $display("FAIL noise_qmax got %0d want 200", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL noise_qmin got %0d want 0", Qmin); end
   endtask

   task automatic test_timeout();
      int t0, v0, c;
      do_reset();
      feed(8'd0);
      feed(8'd200);
      feed(8'd0);
      feed(8'd200);
      t0 = nto;
      for (int i = 0; i < 4095; i++) feed(8'd200);
      #1 c = cyc;
      settle();
      checks++; if (nto - t0 !== 1) begin errors++; $display("FAIL to_count got %0d want 1", nto - t0); end
      checks++; if (tocyc !== c + 1) begin errors++; $display("FAIL to_cycle got %0d want %0d", tocyc, c + 1); end
      checks++; if (Qper !== 12'd2) begin errors++; $display("FAIL to_qper got %0d want 2", Qper); end
      checks++; if (Qmax !== 8'd200) begin errors++; $display("FAIL to_qmax got %0d want 200", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL to_qmin got %0d want 0", Qmin); end
      checks++; if (nboth !== 0) begin errors++; $display("FAIL to_overlap got %0d want 0", nboth); end
      // must rearm from SEEK_LOW: only the second crossing reports
      v0 = nvalid;
      feed(8'd200);
      feed(8'd0);
      feed(8'd200);
      feed(8'd0);
      checks++; if (nvalid !== v0) begin errors++; $display("FAIL to_seek got %0d want %0d", nvalid, v0); end
      feed(8'd0);
      feed(8'd200);
      settle();
      checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL to_rearm_count got %0d want 1", nvalid - v0); end
      checks++; if (Qper !== 12'd3) begin errors++; $display("FAIL to_rearm_qper got %0d want 3", Qper); end
   endtask

   task automatic test_square();
      int v0;
      do_reset();
      v0 = nvalid;
      for (int i = 0; i < 40; i++) feed(((i / 5) % 2 == 1) ? 8'd255 : 8'd0);
      settle();
      checks++; if (nvalid - v0 !== 3) begin errors++; $display("FAIL sq_count got %0d want 3", nvalid - v0); end
      checks++; if (Qper !== 12'd10) begin errors++; $display("FAIL sq_qper got %0d want 10", Qper); end
      checks++; if (Qmax !== 8'd255) begin errors++; $display("FAIL sq_qmax got %0d want 255", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL sq_qmin got %0d want 0", Qmin); end
   endtask

   task automatic test_reset_mid();
      int v0, t0;
      do_reset();
      feed(8'd0);
      feed(8'd200);
      feed(8'd0);
      feed(8'd200);
      feed(8'd0);
      checks++; if (Qper !== 12'd2) begin errors++; $display("FAIL mid_pre_qper got %0d want 2", Qper); end
      v0 = nvalid;
      t0 = nto;
      @(negedge inclk);
      rst = 1'b1;
      repeat (2) @(negedge inclk);
      rst = 1'b0;
      checks++; if (Qper !== 12'd0) begin errors++; $display("FAIL mid_qper got %0d want 0", Qper); end
      checks++; if (Qmax !== 8'd0) begin errors++; $display("FAIL mid_qmax got %0d want 0", Qmax); end
      checks++; if (Qmin !== 8'd0) begin errors++; $display("FAIL mid_qmin got %0d want 0", Qmin); end
      checks++; if (nvalid !== v0 || nto !== t0) begin errors++; $display("FAIL mid_pulses got %0d/%0d want %0d/%0d", nvalid, nto, v0, t0); end
      feed(8'd200);
      feed(8'd0);
      feed(8'd200);
      feed(8'd0);
      feed(8'd0);
      feed(8'd200);
      settle();
      checks++; if (nvalid - v0 !== 1) begin errors++; $display("FAIL mid_restart_count got %0d want 1", nvalid - v0); end
      checks++; if (Qper !== 12'd3) begin errors++; $display("FAIL mid_restart_qper got %0d want 3", Qper); end
   endtask

   initial begin
      test_reset();
      test_triangle();
      test_noise();
      test_square();
      test_reset_mid();
      test_timeout();
      checks++; if (nboth !== 0) begin errors++; $display("FAIL final_overlap got %0d want 0", nboth); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
